// File: rtl/seg7_pkg.sv
// Shared seven-segment constants and BCD pattern lookup.
// All patterns are active-low {g,f,e,d,c,b,a} for a common-anode display.
package seg7_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;

  localparam logic [6:0] SEG_TABLE [10] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
    7'h12, 7'h02, 7'h78, 7'h00, 7'h10
  };

  // Non-decimal codes 10-15 render as a dash so bad counter output is visible.
  function automatic logic [6:0] bcd_to_seg(input logic [3:0] bcd);
    logic [6:0] seg;
    if (bcd <= 4'd9) seg = SEG_TABLE[bcd];
    else             seg = SEG_DASH;
    return seg;
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational digit decoder: one BCD code plus a blank request to segment lines.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [3:0] bcd_i,
  input  logic       blank_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = blank_i ? SEG_BLANK : bcd_to_seg(bcd_i);
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Multiplexed seven-segment scan driver with per-frame snapshot, leading-zero
// blanking, dead time between digits and fully registered active-low outputs.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int DIGITS      = 4,
  parameter int REFRESH_DIV = 1000,
  parameter int GUARD       = 2
) (
  input  logic                  Clk,
  input  logic                  Rst_n,
  input  logic [4*DIGITS-1:0]   Bcd,
  input  logic [DIGITS-1:0]     Dp_in,
  input  logic                  Blank_lz,
  output logic [6:0]            Seg,
  output logic                  Dp,
  output logic [DIGITS-1:0]     An,
  output logic                  Frame_done
);

  localparam int CNT_W  = $clog2(REFRESH_DIV);
  localparam int SLOT_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0]  CNT_GUARD = CNT_W'(GUARD);
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(DIGITS - 1);

  if (DIGITS < 1 || DIGITS > 8) begin : g_bad_digits
    $error("seg7_scan_driver: DIGITS must be in 1..8");
  end
  if (REFRESH_DIV < 2) begin : g_bad_div
    $error("seg7_scan_driver: REFRESH_DIV must be at least 2");
  end
  if (GUARD < 0 || GUARD > REFRESH_DIV - 1) begin : g_bad_guard
    $error("seg7_scan_driver: GUARD must be in 0..REFRESH_DIV-1");
  end

  logic [CNT_W-1:0]          div_cnt_q, div_cnt_d;
  logic [SLOT_W-1:0]         slot_q, slot_d;
  logic [DIGITS-1:0][3:0]    snap_bcd_q;
  logic [DIGITS-1:0]         snap_dp_q;
  logic [6:0]                seg_q, seg_d;
  logic                      dp_q, dp_d;
  logic [DIGITS-1:0]         an_q, an_d;
  logic                      frame_done_q;

  logic                      slot_wrap;
  logic                      frame_wrap;
  logic                      zero_run;
  logic [DIGITS-1:0]         lz_blank;
  logic [3:0]                cur_digit;
  logic                      cur_blank;
  logic                      cur_dp;
  logic                      in_guard;

  always_comb begin
    slot_wrap  = (div_cnt_q == CNT_LAST);
    frame_wrap = slot_wrap && (slot_q == SLOT_LAST);
    div_cnt_d  = slot_wrap ? '0 : div_cnt_q + 1'b1;
    slot_d     = slot_q;
    if (slot_wrap) slot_d = (slot_q == SLOT_LAST) ? '0 : slot_q + 1'b1;
  end

  // A digit is a leading zero only if it and every more significant digit are 0.
  always_comb begin
    zero_run = 1'b1;
    lz_blank = '0;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      zero_run    = zero_run && (snap_bcd_q[i] == 4'd0);
      lz_blank[i] = Blank_lz && zero_run;
    end
  end

  always_comb begin
    cur_digit = snap_bcd_q[slot_q];
    cur_blank = lz_blank[slot_q];
    cur_dp    = snap_dp_q[slot_q];
    in_guard  = (GUARD != 0) && (div_cnt_q < CNT_GUARD);
    dp_d      = cur_blank | ~cur_dp;
    an_d      = in_guard ? '1 : ~(DIGITS'(1) << slot_q);
  end

  seg7_decode u_decode (
    .bcd_i   (cur_digit),
    .blank_i (cur_blank),
    .seg_o   (seg_d)
  );

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      div_cnt_q    <= '0;
      slot_q       <= '0;
      snap_bcd_q   <= '0;
      snap_dp_q    <= '0;
      seg_q        <= SEG_BLANK;
      dp_q         <= 1'b1;
      an_q         <= '1;
      frame_done_q <= 1'b0;
    end else begin
      div_cnt_q    <= div_cnt_d;
      slot_q       <= slot_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      an_q         <= an_d;
      frame_done_q <= frame_wrap;
      if (frame_wrap) begin
        snap_bcd_q <= Bcd;
        snap_dp_q  <= Dp_in;
      end
    end
  end

  assign Seg        = seg_q;
  assign Dp         = dp_q;
  assign An         = an_q;
  assign Frame_done = frame_done_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver: frame-by-frame directed vectors feed an expected
// queue of visible digit slots and Frame_done times; a negedge monitor checks them.
module tb_seg7_scan_driver;

  localparam int DIGITS      = 4;
  localparam int REFRESH_DIV = 8;
  localparam int GUARD       = 2;
  localparam int W           = 28;

  logic        Clk = 1'b0;
  logic        Rst_n = 1'b0;
  logic [15:0] Bcd;
  logic [3:0]  Dp_in;
  logic        Blank_lz;
  logic [6:0]  Seg;
  logic        Dp;
  logic [3:0]  An;
  logic        Frame_done;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit mon_en = 1'b0;

  // Entry: {start cycle[15:0], an[3:0], seg[6:0], dp}
  logic [W-1:0]  exp_q[$];
  logic [15:0]   fd_q[$];

  seg7_scan_driver #(
    .DIGITS      (DIGITS),
    .REFRESH_DIV (REFRESH_DIV),
    .GUARD       (GUARD)
  ) dut (
    .Clk        (Clk),
    .Rst_n      (Rst_n),
    .Bcd        (Bcd),
    .Dp_in      (Dp_in),
    .Blank_lz   (Blank_lz),
    .Seg        (Seg),
    .Dp         (Dp),
    .An         (An),
    .Frame_done (Frame_done)
  );

  // ---------------- clock / reset-relative cycle count ----------------
  always #5 Clk = ~Clk;

  always @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // ---------------- driver tasks ----------------
  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge Clk);
  endtask

  task automatic push_slots(input int base, input logic [27:0] segs,
                            input logic [3:0] edp, input int nslots);
    logic [3:0] an_exp;
    for (int i = 0; i < nslots; i++) begin
      an_exp = ~(4'b0001 << i);
      exp_q.push_back({16'(base + REFRESH_DIV * i + GUARD + 1), an_exp, segs[7*i +: 7], edp[i]});
    end
  endtask

  // Runs one whole frame: segs = {d3,d2,d1,d0} expected patterns, edp = expected Dp per digit.
  // The next word is applied during slot 2 so it must not appear before the next frame.
  task automatic do_frame(input logic blz, input logic [15:0] nb, input logic [3:0] nd,
                          input logic [27:0] segs, input logic [3:0] edp);
    int base;
    base = cyc;
    Blank_lz = blz;
    push_slots(base, segs, edp, DIGITS);
    fd_q.push_back(16'(base + DIGITS * REFRESH_DIV));
    wait_cyc(base + 2 * REFRESH_DIV + 2);
    Bcd   = nb;
    Dp_in = nd;
    wait_cyc(base + DIGITS * REFRESH_DIV);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_seg"}, Seg, 7'h7F);
    check({tag, "_dp"}, Dp, 1'b1);
    check({tag, "_an"}, An, 4'hF);
    check({tag, "_frame_done"}, Frame_done, 1'b0);
  endtask

  // ---------------- monitor / scoreboard ----------------
  logic [W-1:0] cur;
  logic [3:0]   prev_an;
  int           run_len;
  int           gap_len;
  bit           have_prev;

  always @(negedge Clk) begin
    if (!Rst_n || !mon_en) begin
      prev_an   = 4'hF;
      run_len   = 0;
      gap_len   = 0;
      have_prev = 1'b0;
    end else begin
      check("an_at_most_one_low", ($countones(~An) <= 1), 1);
      if (An != prev_an) begin
        if (prev_an != 4'hF) check("an_low_length", run_len, REFRESH_DIV - GUARD);
        if (An != 4'hF) begin
          if (have_prev) check("an_dead_time", (gap_len >= GUARD), 1);
          if (exp_q.size() == 0) begin
            fail_now("slot_unexpected");
          end else begin
            cur = exp_q.pop_front();
            check("slot_start_cycle", cyc, cur[27:12]);
            check("slot_an", An, cur[11:8]);
            check("slot_seg", Seg, cur[7:1]);
            check("slot_dp", Dp, cur[0]);
          end
          run_len   = 1;
          gap_len   = 0;
          have_prev = 1'b1;
        end else begin
          gap_len = 1;
        end
      end else if (An != 4'hF) begin
        run_len++;
        check("slot_seg_hold", Seg, cur[7:1]);
        check("slot_dp_hold", Dp, cur[0]);
      end else begin
        gap_len++;
      end
      prev_an = An;

      if (Frame_done === 1'b1) begin
        if (fd_q.size() == 0) fail_now("frame_done_unexpected");
        else check("frame_done_cycle", cyc, fd_q.pop_front());
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int base;
    Bcd      = 16'h1234;
    Dp_in    = 4'b0000;
    Blank_lz = 1'b0;
    repeat (3) @(negedge Clk);
    check_reset_outputs("por");

    Rst_n  = 1'b1;
    mon_en = 1'b1;

    do_frame(1'b0, 16'h1234, 4'b0000, {7'h40, 7'h40, 7'h40, 7'h40}, 4'b1111);
    do_frame(1'b0, 16'h0907, 4'b0100, {7'h79, 7'h24, 7'h30, 7'h19}, 4'b1111);
    do_frame(1'b1, 16'h0000, 4'b1001, {7'h7F, 7'h10, 7'h40, 7'h78}, 4'b1011);
    do_frame(1'b1, 16'h00A0, 4'b0000, {7'h7F, 7'h7F, 7'h7F, 7'h40}, 4'b1110);
    do_frame(1'b1, 16'h0000, 4'b0000, {7'h7F, 7'h7F, 7'h3F, 7'h40}, 4'b1111);
    do_frame(1'b0, 16'h8F56, 4'b1111, {7'h40, 7'h40, 7'h40, 7'h40}, 4'b1111);
    do_frame(1'b1, 16'hF000, 4'b0000, {7'h00, 7'h3F, 7'h12, 7'h02}, 4'b0000);
    do_frame(1'b1, 16'h0800, 4'b0100, {7'h3F, 7'h40, 7'h40, 7'h40}, 4'b1111);

    // Frame showing 0800; reset hits while digit 2 is lit.
    base = cyc;
    Blank_lz = 1'b1;
    push_slots(base, {7'h7F, 7'h00, 7'h40, 7'h40}, 4'b1011, 3);
    wait_cyc(base + 2 * REFRESH_DIV + 5);
    #1 Rst_n = 1'b0;
    #1 check_reset_outputs("async_rst");
    check("queue_empty_at_rst", exp_q.size(), 0);
    exp_q.delete();
    fd_q.delete();
    Bcd   = 16'h0042;
    Dp_in = 4'b0000;
    repeat (3) @(negedge Clk);
    check_reset_outputs("held_rst");
    Rst_n = 1'b1;

    do_frame(1'b1, 16'h0042, 4'b0000, {7'h7F, 7'h7F, 7'h7F, 7'h40}, 4'b1111);
    do_frame(1'b1, 16'h0042, 4'b0000, {7'h7F, 7'h7F, 7'h19, 7'h24}, 4'b1111);

    repeat (2) @(negedge Clk);
    check("slots_all_seen", exp_q.size(), 0);
    check("frame_done_all_seen", fd_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    fail_now("watchdog_timeout");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg7_scan_driver.md
# seg7_scan_driver

Multiplexed seven-segment display driver that sits directly downstream of the one-digit mod-10 counters and consumes their 4-bit BCD digits. It latches a multi-digit BCD word once per scan frame and time-multiplexes it onto shared segment lines and per-digit anodes. It also provides leading-zero blanking, invalid-code indication and anti-ghosting dead time. All outputs are registered and active-low for a common-anode board.

## Interface
- DIGITS, 4, number of digits scanned (legal 1..8)
- REFRESH_DIV, 1000, Clk cycles per digit slot (legal ≥ 2)
- GUARD, 2, cycles at the start of each slot with all anodes off (legal 0..REFRESH_DIV-1)

Ports:
- Clk  in  1  system clock; all state changes on posedge
- Rst_n  in  1  reset, asynchronous and active-low; one clock domain only
- Bcd  in  4*DIGITS  packed BCD digits, Bcd[4i+3:4i] is digit i, digit 0 least significant
- Dp_in  in  DIGITS  decimal point request per digit, active-high
- Blank_lz  in  1  1 = blank leading zeros
- Seg  out  7  segments {g,f,e,d,c,b,a}, active-low
- Dp  out  1  decimal point segment, active-low
- An  out  DIGITS  digit anode enables, active-low, at most one low at any time
- Frame_done  out  1  one-cycle pulse marking the start of a new frame (snapshot taken)

## Operation
- Internal state: div_cnt (0..REFRESH_DIV-1), slot (0..DIGITS-1), snapshot of Bcd and Dp_in.
- div_cnt increments every cycle. At REFRESH_DIV-1 it wraps to 0 and slot advances. slot wraps DIGITS-1 → 0.
- Snapshot load happens on the edge where div_cnt=REFRESH_DIV-1 and slot=DIGITS-1, i.e. the wrap into slot 0. Bcd/Dp_in changes mid-frame are never shown until the next frame.
- Anode: An = ~(1<<slot) when div_cnt ≥ GUARD, else all ones (dead time).
- Digit decode of snapshot digit at slot:
  - 0-9: standard patterns. Active-low values: 0=7'h40, 1=7'h79, 2=7'h24, 3=7'h30, 4=7'h19, 5=7'h12, 6=7'h02, 7=7'h78, 8=7'h00, 9=7'h10.
  - Codes 10-15: dash, 7'h3F.
- Leading-zero blanking: when Blank_lz=1, digit i (i ≥ 1) is blanked if snapshot digits i..DIGITS-1 are all 0. A blanked digit drives Seg=7'h7F and Dp=1. Digit 0 is never blanked. Codes 10-15 count as non-zero.
- Dp = ~snapshot_dp[slot], except on blanked digits.
- Seg/Dp are driven during dead time too; An alone gates visibility.
- Frame_done = 1 for exactly one cycle, in the cycle after the snapshot load edge.

## Timing
- Reset (Rst_n=0, asynchronous, takes effect immediately, including mid-frame):
  - Seg=7'h7F, Dp=1, An=all ones, Frame_done=0.
  - div_cnt=0, slot=0, snapshot=0.
- Registered outputs lag internal state by 1 cycle. First anode activation: An[0] goes low GUARD+1 cycles after the first posedge with Rst_n=1.
- Before the first snapshot load, the display shows snapshot 0: "0" on digit 0, other digits blank if Blank_lz=1, else "0".
- Frame length = DIGITS*REFRESH_DIV cycles. Each anode is low for REFRESH_DIV-GUARD consecutive cycles per frame.
- The first Frame_done pulse occurs DIGITS*REFRESH_DIV cycles after reset release, then periodically with that period.
- Blank_lz is sampled live (not snapshotted). A change takes effect on the next registered output.
- Parameter violations are caught by elaboration-time assertions.

## Structure
- Shared package seg7_pkg holds:
  - segment constants SEG_BLANK=7'h7F and SEG_DASH=7'h3F
  - the 10-entry digit pattern table
  - function bcd_to_seg(4-bit) returning the 7-bit active-low pattern
- One combinational sub-module, seg7_decode (BCD in, blank in → Seg), is natural. The scan/snapshot/blanking logic stays in seg7_scan_driver.

## Test plan
All scenarios use DIGITS=4, REFRESH_DIV=8, GUARD=2.
- Reset release with Bcd=16'h1234, Blank_lz=0 → An all ones for cycles 0-2. An=4'b1110 with Seg=7'h40 for cycles 3-8. Frame_done pulses at cycle 32. The next frame shows digit 0=7'h19, 1=7'h30, 2=7'h24, 3=7'h79.
- Bcd=16'h0907, Blank_lz=1, after one Frame_done → digit 3 Seg=7'h7F, digit 2=7'h10, digit 1=7'h40 (not leading), digit 0=7'h78.
- Bcd=16'h0000, Blank_lz=1 → digits 3-1 blank, digit 0=7'h40. Bcd=16'h00A0 → digit 1 shows dash 7'h3F and digit 0=7'h40.
- Bcd changed mid-frame (during slot 2) → displayed values unchanged until the cycle after the next Frame_done.
- Rst_n pulsed low during slot 2 for 3 cycles → outputs go to reset values immediately, without a clock edge. Scanning restarts at slot 0 after release, with snapshot 0.
- Continuous checker: An never has more than one zero bit. Each anode is low exactly 6 consecutive cycles per 32-cycle frame, with ≥ 2 all-off cycles between different anodes.
